// File: rtl/dr_pkg.sv
// Shared dual-rail encodings, decode helper and sink FSM state type.
package dr_pkg;

    typedef logic [1:0] dr_bit_t;

    localparam dr_bit_t DR_NULL = 2'b00;
    localparam dr_bit_t DR_ZERO = 2'b01;
    localparam dr_bit_t DR_ONE  = 2'b10;
    localparam dr_bit_t DR_ILL  = 2'b11;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } sink_state_e;

    // The true rail carries the binary value; an illegal pair decodes as 1.
    function automatic logic dr_decode(input dr_bit_t rail);
        return rail[1];
    endfunction

endpackage

// File: rtl/dr_fp_sync_sink_sync_ff.sv
// Multi-flop synchronizer chain for a single-bit level crossing into clk.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    assign chain_d[0] = d_i;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            assign chain_d[gi] = chain_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/dr_fp_sync_sink.sv
// Four-phase dual-rail sink: synchronized completion/spacer detection, token
// capture into a small FIFO, and a valid/ready binary output stream.
module dr_fp_sync_sink
    import dr_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  in,
    output logic                   ack_o,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] pair_valid;
    logic [WIDTH-1:0] pair_null;
    logic [WIDTH-1:0] pair_ill;
    logic [WIDTH-1:0] data_dec;
    logic             complete;
    logic             spacer;
    logic             illegal;
    logic             s_complete;
    logic             s_spacer;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
            assign pair_valid[gi] = (in[gi] != DR_NULL);
            assign pair_null[gi]  = (in[gi] == DR_NULL);
            assign pair_ill[gi]   = (in[gi] == DR_ILL);
            assign data_dec[gi]   = dr_decode(in[gi]);
        end
    endgenerate

    assign complete = &pair_valid;
    assign spacer   = &pair_null;
    assign illegal  = |pair_ill;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_complete (
        .clk (clk),
        .rst (rst),
        .d_i (complete),
        .q_o (s_complete)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_spacer (
        .clk (clk),
        .rst (rst),
        .d_i (spacer),
        .q_o (s_spacer)
    );

    sink_state_e      state_q;
    sink_state_e      state_d;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             err_q;
    logic             err_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] fifo_mem [DEPTH];

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && dout_ready;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            WAIT_DATA: begin
                // Both flags are checked so a one-cycle skew between chains cannot misfire.
                if (s_complete && !s_spacer && !full) begin
                    push    = 1'b1;
                    err_d   = err_q | illegal;
                    state_d = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (s_spacer && !s_complete) begin
                    state_d = WAIT_DATA;
                end
            end
            default: state_d = WAIT_DATA;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_DATA;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage holds no reset; occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= data_dec;
        end
    end

    assign ack_o      = (state_q == WAIT_NULL);
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign err        = err_q;

endmodule
